ov7670_config_ctrl: RTL



---
 rtl/ov7670_cfg_pkg.sv | 32 +++
 rtl/ov7670_config_ctrl_delay.sv | 27 ++
 rtl/ov7670_config_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ov7670_cfg_pkg.sv
// Shared types and constants for the OV7670 configuration sequencer.
package ov7670_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAT,
        CHECK,
        ISSUE,
        WAITACK,
        SETTLE,
        DONE
    } cfg_state_e;

    localparam logic [7:0]  COM7_ADDR   = 8'h12;
    localparam int unsigned LUT_LATENCY = 2;
    localparam logic [15:0] END_MARKER  = 16'hFFFF;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // COM7 with bit7 set is a sensor soft reset and needs a long settle.
    function automatic logic is_soft_reset(input logic [7:0] addr,
                                           input logic [7:0] data);
        return (addr == COM7_ADDR) && data[7];
    endfunction

endpackage

// File: rtl/ov7670_config_ctrl_delay.sv
// Loadable down-counter with a zero flag; shared by the latency wait,
// the inter-write settle and the ACK timeout.
module cfg_delay_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/ov7670_config_ctrl.sv
// Walks the OV7670 register LUT and hands each {reg,value} pair to the
// SCCB write engine, with LUT latency, soft-reset settle and ACK timeout.
module ov7670_config_ctrl
    import ov7670_cfg_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 25000000,
    parameter int unsigned RESET_WAIT  = 25000,
    parameter int unsigned GAP_CYCLES  = 16,
    parameter int unsigned ACK_TIMEOUT = 65535,
    parameter logic [7:0]  SCCB_ID     = 8'h42
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] lut_command,
    input  logic        lut_finished,
    output logic        lut_resend,
    output logic        lut_advance,
    input  logic        sccb_ready,
    output logic        sccb_start,
    output logic [7:0]  sccb_id,
    output logic [7:0]  sccb_addr,
    output logic [7:0]  sccb_data,
    input  logic        sccb_done,
    output logic        busy,
    output logic        config_done,
    output logic        error
);

    localparam int unsigned CNT_MAX = max3(RESET_WAIT, GAP_CYCLES, ACK_TIMEOUT);
    localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    // LAT is entered with the strobe already on the LUT, so loading
    // LATENCY-1 keeps the state for exactly LUT_LATENCY cycles.
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LUT_LATENCY - 1);
    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RESET_WAIT);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] ACK_LOAD = CNT_W'(ACK_TIMEOUT);

    if (CLK_HZ == 0) begin : g_bad_clk_hz
        $error("CLK_HZ must be non-zero");
    end

    cfg_state_e  state_q;
    logic        resend_q;
    logic        advance_q;
    logic        sccb_start_q;
    logic [7:0]  addr_q;
    logic [7:0]  data_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;

    logic             cnt_load_d;
    logic [CNT_W-1:0] cnt_val_d;
    logic             cnt_zero;
    logic             lut_end;

    assign lut_end = lut_finished || (lut_command == END_MARKER);

    cfg_delay_counter #(
        .WIDTH (CNT_W)
    ) u_delay (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load_d),
        .load_val_i (cnt_val_d),
        .zero_o     (cnt_zero)
    );

    // Counter loads must land on the same edge as the state change.
    always_comb begin
        cnt_load_d = 1'b0;
        cnt_val_d  = '0;
        if (start) begin
            cnt_load_d = 1'b1;
            cnt_val_d  = LAT_LOAD;
        end else begin
            unique case (state_q)
                ISSUE: begin
                    if (sccb_ready) begin
                        cnt_load_d = 1'b1;
                        cnt_val_d  = ACK_LOAD;
                    end
                end
                WAITACK: begin
                    if (sccb_done) begin
                        cnt_load_d = 1'b1;
                        cnt_val_d  = is_soft_reset(addr_q, data_q) ? RST_LOAD : GAP_LOAD;
                    end
                end
                SETTLE: begin
                    if (cnt_zero) begin
                        cnt_load_d = 1'b1;
                        cnt_val_d  = LAT_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            resend_q     <= 1'b1;
            advance_q    <= 1'b0;
            sccb_start_q <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            resend_q     <= 1'b0;
            advance_q    <= 1'b0;
            sccb_start_q <= 1'b0;
            // start from any state rewinds the LUT; an in-flight write is abandoned
            if (start) begin
                state_q  <= LAT;
                resend_q <= 1'b1;
                busy_q   <= 1'b1;
                done_q   <= 1'b0;
                error_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        resend_q <= 1'b1;
                    end
                    LAT: begin
                        if (cnt_zero) begin
                            state_q <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (lut_end) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            addr_q  <= lut_command[15:8];
                            data_q  <= lut_command[7:0];
                            state_q <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (sccb_ready) begin
                            sccb_start_q <= 1'b1;
                            state_q      <= WAITACK;
                        end
                    end
                    WAITACK: begin
                        if (sccb_done) begin
                            state_q <= SETTLE;
                        end else if (cnt_zero) begin
                            error_q  <= 1'b1;
                            busy_q   <= 1'b0;
                            resend_q <= 1'b1;
                            state_q  <= IDLE;
                        end
                    end
                    SETTLE: begin
                        if (cnt_zero) begin
                            advance_q <= 1'b1;
                            state_q   <= LAT;
                        end
                    end
                    DONE: ;
                    default: begin
                        resend_q <= 1'b1;
                        state_q  <= IDLE;
                    end
                endcase
            end
        end
    end

    assign lut_resend  = resend_q;
    assign lut_advance = advance_q;
    assign sccb_start  = sccb_start_q;
    assign sccb_id     = SCCB_ID;
    assign sccb_addr   = addr_q;
    assign sccb_data   = data_q;
    assign busy        = busy_q;
    assign config_done = done_q;
    assign error       = error_q;

endmodule
